// File: rtl/cassette_pkg.sv
// Shared types and constants for the cassette playback and record blocks.
package cassette_pkg;

  typedef enum logic [1:0] {StIdle, StHunt, StLocked} state_e;

  localparam logic [7:0] LEADER_BYTE = 8'h55;
  localparam logic [5:0] DAC_MID     = 6'd32;

  // Thresholds are clk dividers so the defaults track CLK_HZ.
  localparam int unsigned DefClkHz     = 50_000_000;
  localparam int unsigned BitThreshDiv = 1600;
  localparam int unsigned MinPeriodDiv = 5000;
  localparam int unsigned GapPeriodDiv = 600;
  localparam int unsigned DefHyst      = 4;
  localparam int unsigned DefAddrW     = 16;

endpackage

// File: rtl/fsk_edge_timer.sv
// Synchronises the DAC, squares it with hysteresis and times rising-edge
// periods into FSK bits.
module fsk_edge_timer
  import cassette_pkg::*;
#(
  parameter int unsigned BIT_THRESH = 31250,
  parameter int unsigned MIN_PERIOD = 10000,
  parameter int unsigned GAP_PERIOD = 83333,
  parameter int unsigned HYST       = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [5:0] dac_i,
  output logic       bit_valid_o,
  output logic       bit_val_o,
  output logic       gap_o
);

  localparam int unsigned CntW = $clog2(GAP_PERIOD + 1);
  localparam logic [CntW-1:0] MinCnt = CntW'(MIN_PERIOD);
  localparam logic [CntW-1:0] ThrCnt = CntW'(BIT_THRESH);
  localparam logic [CntW-1:0] GapCnt = CntW'(GAP_PERIOD);
  localparam logic [5:0] HiThr = 6'(DAC_MID + HYST);
  localparam logic [5:0] LoThr = 6'(DAC_MID - HYST);

  logic [5:0]      dac_q1, dac_q2;
  logic            level_q, level_d;
  logic            started_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise, accept;

  always_comb begin
    level_d = level_q;
    if (dac_q2 >= HiThr) begin
      level_d = 1'b1;
    end else if (dac_q2 <= LoThr) begin
      level_d = 1'b0;
    end
  end

  // Edges arriving too soon are glitches: they neither yield a bit nor restart timing.
  assign rise        = level_d & ~level_q;
  assign accept      = rise && (cnt_q >= MinCnt);
  assign gap_o       = (cnt_q == GapCnt);
  assign bit_valid_o = accept && started_q && !gap_o;
  assign bit_val_o   = (cnt_q >= ThrCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || accept) begin
      cnt_d = '0;
    end else if (!gap_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dac_q1    <= '0;
      dac_q2    <= '0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      dac_q1  <= dac_i;
      dac_q2  <= dac_q1;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      if (!en_i) begin
        started_q <= 1'b0;
      end else if (accept) begin
        started_q <= 1'b1;
      end else if (gap_o) begin
        started_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder: decodes FSK from the sound DAC, aligns on the 0x55
// leader and writes raw CAS bytes into the cassette SRAM.
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DefClkHz,
  parameter int unsigned BIT_THRESH = CLK_HZ / BitThreshDiv,
  parameter int unsigned MIN_PERIOD = CLK_HZ / MinPeriodDiv,
  parameter int unsigned GAP_PERIOD = CLK_HZ / GapPeriodDiv,
  parameter int unsigned HYST       = DefHyst,
  parameter int unsigned ADDR_W     = DefAddrW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [5:0]        dac_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] byte_count_o,
  output logic              locked_o,
  output logic              overflow_o
);

  logic bit_valid, bit_val, gap;

  fsk_edge_timer #(
    .BIT_THRESH (BIT_THRESH),
    .MIN_PERIOD (MIN_PERIOD),
    .GAP_PERIOD (GAP_PERIOD),
    .HYST       (HYST)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .dac_i       (dac_i),
    .bit_valid_o (bit_valid),
    .bit_val_o   (bit_val),
    .gap_o       (gap)
  );

  state_e            state_q;
  logic [7:0]        sr_q, sr_shift;
  logic [2:0]        bitcnt_q;
  logic              locked_q, wr_q, ovf_q;
  logic [ADDR_W-1:0] addr_q, count_q;
  logic [7:0]        data_q;
  logic              byte_done, do_wr;

  always_comb begin
    sr_shift  = {bit_val, sr_q[7:1]};
    byte_done = en_i && bit_valid &&
                (((state_q == StHunt) && (sr_shift == LEADER_BYTE)) ||
                 ((state_q == StLocked) && (bitcnt_q == 3'd7)));
    // A coincident clear drops the byte; a full buffer drops every byte.
    do_wr     = byte_done && !clear_i && !ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bitcnt_q <= '0;
      locked_q <= 1'b0;
      wr_q     <= 1'b0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      wr_q <= do_wr;
      if (do_wr) begin
        addr_q <= count_q;
        data_q <= sr_shift;
        if (&count_q) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + ADDR_W'(1);
        end
      end
      if (clear_i) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end

      if (!en_i) begin
        state_q  <= StIdle;
        sr_q     <= '0;
        bitcnt_q <= '0;
        locked_q <= 1'b0;
      end else if (gap) begin
        state_q  <= StHunt;
        sr_q     <= '0;
        bitcnt_q <= '0;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StHunt;
          StHunt: begin
            if (bit_valid) begin
              sr_q <= sr_shift;
              if (sr_shift == LEADER_BYTE) begin
                state_q  <= StLocked;
                bitcnt_q <= '0;
                locked_q <= 1'b1;
              end
            end
          end
          StLocked: begin
            if (bit_valid) begin
              sr_q     <= sr_shift;
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ram_addr_o   = addr_q;
  assign ram_data_o   = data_q;
  assign ram_wr_o     = wr_q;
  assign byte_count_o = count_q;
  assign locked_o     = locked_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cassette_rec.sv
// Bench for cassette_rec: scaled clock (thresholds 31/10/83 clks), a 16-bit and a
// 4-bit address instance driven by the same FSK stimulus.
module tb_cassette_rec;

  localparam int unsigned ClkHz = 50000;
  localparam logic [5:0]  Hi = 6'd56;
  localparam logic [5:0]  Lo = 6'd8;
  localparam int          PerOne  = 42;
  localparam int          PerZero = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clear;
  logic [5:0]  dac;
  logic [15:0] a_addr, a_cnt;
  logic [7:0]  a_data, b_data;
  logic        a_wr, a_lock, a_ovf, b_wr, b_lock, b_ovf;
  logic [3:0]  b_addr, b_cnt;

  cassette_rec #(.CLK_HZ(ClkHz)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .dac_i(dac),
    .ram_addr_o(a_addr), .ram_data_o(a_data), .ram_wr_o(a_wr),
    .byte_count_o(a_cnt), .locked_o(a_lock), .overflow_o(a_ovf)
  );

  cassette_rec #(.CLK_HZ(ClkHz), .ADDR_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .dac_i(dac),
    .ram_addr_o(b_addr), .ram_data_o(b_data), .ram_wr_o(b_wr),
    .byte_count_o(b_cnt), .locked_o(b_lock), .overflow_o(b_ovf)
  );

  logic [23:0] qa[$];
  logic [23:0] qb[$];
  always @(negedge clk) begin
    if (a_wr) qa.push_back({a_addr, a_data});
    if (b_wr) qb.push_back({12'd0, b_addr, b_data});
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] tx;
    logic       glitch;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_wr(input string name, input logic [23:0] got,
                          input logic [15:0] addr, input logic [7:0] data);
    check(name, 32'(got), 32'({addr, data}));
  endtask

  task automatic send_bit(input logic b, input logic g);
    int p = b ? PerOne : PerZero;
    int h = p / 2;
    dac = Hi;
    if (g) begin
      tick(3);
      dac = Lo;
      tick(2);
      dac = Hi;
      tick(h - 5);
    end else begin
      tick(h);
    end
    dac = Lo;
    tick(p - h);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic g);
    for (int i = 0; i < 8; i++) send_bit(v[i], g);
  endtask

  // Closing rising edge so the last bit's period is measured.
  task automatic term();
    dac = Hi;
    tick(5);
    dac = Lo;
    tick(5);
  endtask

  task automatic restart();
    en = 1'b0;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    en = 1'b1;
    qa.delete();
    qb.delete();
    tick(20);
  endtask

  logic [7:0] ld;
  logic [7:0] four;

  initial begin
    vecs[0] = '{tx: 8'h3C, glitch: 1'b0, exp: 8'h3C};
    vecs[1] = '{tx: 8'hA1, glitch: 1'b0, exp: 8'hA1};
    vecs[2] = '{tx: 8'h00, glitch: 1'b0, exp: 8'h00};
    vecs[3] = '{tx: 8'hFF, glitch: 1'b0, exp: 8'hFF};
    vecs[4] = '{tx: 8'h3C, glitch: 1'b1, exp: 8'h3C};
    vecs[5] = '{tx: 8'h96, glitch: 1'b1, exp: 8'h96};
    ld   = 8'h55;
    four = 8'b0000_1101;

    rst_n = 1'b1; en = 1'b0; clear = 1'b0; dac = Lo;
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_wr", 32'(a_wr), 32'd0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_lock", 32'(a_lock), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Leader lock and 16 leader bytes.
    restart();
    send_byte(ld, 1'b0);
    check("lock_before_8th", 32'(a_lock), 32'd0);
    send_bit(ld[0], 1'b0);
    check("lock_after_8th", 32'(a_lock), 32'd1);
    check("first_wr_count", 32'(qa.size()), 32'd1);
    for (int i = 1; i < 8; i++) send_bit(ld[i], 1'b0);
    repeat (14) send_byte(ld, 1'b0);
    term();
    check("lead_wr_count", 32'(qa.size()), 32'd16);
    for (int i = 0; i < 16; i++) check_wr("lead_wr", qa[i], 16'(i), 8'h55);
    check("lead_cnt", 32'(a_cnt), 32'd16);
    check("lead_addr_hold", 32'(a_addr), 32'd15);

    // Leader followed by one data byte, table driven.
    for (int v = 0; v < 6; v++) begin
      restart();
      send_byte(ld, 1'b0);
      send_byte(vecs[v].tx, vecs[v].glitch);
      term();
      check("vec_wr_count", 32'(qa.size()), 32'd2);
      check_wr("vec_wr0", qa[0], 16'd0, 8'h55);
      check_wr("vec_wr1", qa[1], 16'd1, vecs[v].exp);
      check("vec_cnt", 32'(a_cnt), 32'd2);
      check("vec_data_out", 32'(a_data), 32'(vecs[v].exp));
    end

    // Gap drops alignment; relock afterwards.
    restart();
    send_byte(ld, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(four[i], 1'b0);
    term();
    tick(50);
    check("gap_lock_before", 32'(a_lock), 32'd1);
    tick(40);
    check("gap_lock_after", 32'(a_lock), 32'd0);
    check("gap_wr_count", 32'(qa.size()), 32'd1);
    send_byte(ld, 1'b0);
    send_byte(8'hA1, 1'b0);
    term();
    check("relock_wr_count", 32'(qa.size()), 32'd3);
    check_wr("relock_wr1", qa[1], 16'd1, 8'h55);
    check_wr("relock_wr2", qa[2], 16'd2, 8'hA1);

    // Clear coinciding with a write drops that byte.
    restart();
    send_byte(ld, 1'b0);
    send_byte(8'h3C, 1'b0);
    dac = Hi;
    tick(1);
    clear = 1'b1;
    tick(3);
    clear = 1'b0;
    tick(2);
    dac = Lo;
    tick(5);
    check("clr_wr_count", 32'(qa.size()), 32'd1);
    check("clr_cnt", 32'(a_cnt), 32'd0);
    check("clr_lock_kept", 32'(a_lock), 32'd1);

    // Mid-level oscillation inside the hysteresis band makes no edges.
    restart();
    send_byte(ld, 1'b0);
    dac = Hi;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      dac = 6'd30;
      tick(15);
      dac = 6'd34;
      tick(15);
      if (i == 1) check("hyst_lock_early", 32'(a_lock), 32'd1);
    end
    dac = Lo;
    check("hyst_lock_late", 32'(a_lock), 32'd0);
    check("hyst_wr_count", 32'(qa.size()), 32'd1);
    tick(5);

    // Overflow on the 4-bit instance.
    restart();
    send_byte(ld, 1'b0);
    for (int k = 1; k < 20; k++) send_byte(8'(k * 37 + 1), 1'b0);
    term();
    check("ovf_a_count", 32'(qa.size()), 32'd20);
    check_wr("ovf_a_last", qa[19], 16'd19, 8'hC0);
    check("ovf_a_cnt", 32'(a_cnt), 32'd20);
    check("ovf_a_flag", 32'(a_ovf), 32'd0);
    check("ovf_b_count", 32'(qb.size()), 32'd16);
    check_wr("ovf_b_last", qb[15], 16'd15, 8'h2C);
    check("ovf_b_cnt", 32'(b_cnt), 32'd15);
    check("ovf_b_flag", 32'(b_ovf), 32'd1);
    check("ovf_b_lock", 32'(b_lock), 32'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("ovf_clr_b_cnt", 32'(b_cnt), 32'd0);
    check("ovf_clr_b_flag", 32'(b_ovf), 32'd0);
    check("ovf_clr_a_cnt", 32'(a_cnt), 32'd0);

    // en drop mid-byte discards the partial byte.
    restart();
    send_byte(ld, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(four[i], 1'b0);
    check("en_lock_before", 32'(a_lock), 32'd1);
    en = 1'b0;
    tick(1);
    check("en_lock_after", 32'(a_lock), 32'd0);
    tick(100);
    check("en_wr_count", 32'(qa.size()), 32'd1);
    check("en_cnt_kept", 32'(a_cnt), 32'd1);

    // Asynchronous reset mid-stream.
    en = 1'b1;
    tick(20);
    send_byte(ld, 1'b0);
    send_bit(1'b1, 1'b0);
    check("arst_pre_lock", 32'(a_lock), 32'd1);
    check("arst_pre_cnt", 32'(a_cnt), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(a_addr), 32'd0);
    check("arst_data", 32'(a_data), 32'd0);
    check("arst_cnt", 32'(a_cnt), 32'd0);
    check("arst_lock", 32'(a_lock), 32'd0);
    check("arst_wr", 32'(a_wr), 32'd0);
    check("arst_ovf", 32'(a_ovf), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
